// File: rtl/common_bus_arb.sv
// Registered common-bus multiplexer with direct-select and round-robin arbitration.
// Optional COMMON_BUS_PARITY_EN adds a bus_par output: the XOR of the captured data, registered with bus_data.
module common_bus_arb #(
  parameter int NUM_SRC = 6,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_vld,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      bus_ack,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      bus_valid,
  output logic [SEL_W-1:0]          bus_src,
  output logic [NUM_SRC-1:0]        gnt,
  output logic                      sel_err,
  output logic                      timeout
`ifdef COMMON_BUS_PARITY_EN
  ,output logic                     bus_par
`endif
);

  // state | meaning
  // IDLE  | bus released, a capture may happen on the next edge
  // DRIVE | captured data held on the bus until bus_ack or timeout
  typedef enum logic {IDLE, DRIVE} state_t;

  localparam logic [SEL_W:0] NUM_SRC_V = (SEL_W+1)'(NUM_SRC);
  localparam logic [7:0]     TC_LAST   = 8'(TIMEOUT - 1);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   data_nx;
  logic [SEL_W-1:0]    src_nx;
  logic [NUM_SRC-1:0]  gnt_nx;
  logic                valid_nx, sel_err_nx, timeout_nx;
  logic [SEL_W-1:0]    rr_ptr, rr_nx;
  logic [7:0]          tcnt, tcnt_nx;

  logic                rr_found;
  logic [SEL_W-1:0]    rr_pick;
  logic                sel_ok;
  logic                do_cap;
  logic [SEL_W-1:0]    pick;
  logic [DATA_W-1:0]   cap_data;
  logic [NUM_SRC-1:0]  cap_gnt;

  // Round-robin: choose the set request with the smallest rotated distance from rr_ptr.
  always_comb begin
    int best, d;
    rr_found = 1'b0;
    rr_pick  = '0;
    best     = NUM_SRC;
    d        = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      d = (i >= int'(rr_ptr)) ? i - int'(rr_ptr) : i + NUM_SRC - int'(rr_ptr);
      if (req[i] && d < best) begin
        best     = d;
        rr_pick  = SEL_W'(i);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ok = ({1'b0, sel} < NUM_SRC_V);
    do_cap = 1'b0;
    pick   = '0;
    if (state == IDLE) begin
      if (!mode && sel_vld && sel_ok) begin
        do_cap = 1'b1;
        pick   = sel;
      end else if (mode && rr_found) begin
        do_cap = 1'b1;
        pick   = rr_pick;
      end
    end
  end

  always_comb begin
    cap_data = '0;
    cap_gnt  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pick == SEL_W'(i)) begin
        cap_data   = src_data[i*DATA_W +: DATA_W];
        cap_gnt[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    data_nx    = bus_data;
    src_nx     = bus_src;
    gnt_nx     = gnt;
    valid_nx   = bus_valid;
    sel_err_nx = 1'b0;
    timeout_nx = 1'b0;
    rr_nx      = rr_ptr;
    tcnt_nx    = tcnt;
    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        gnt_nx   = '0;
        if (!mode && sel_vld && !sel_ok)
          sel_err_nx = 1'b1;
        if (mode && do_cap)
          rr_nx = (rr_pick == SEL_W'(NUM_SRC - 1)) ? '0 : rr_pick + 1'b1;
        if (do_cap) begin
          data_nx  = cap_data;
          src_nx   = pick;
          gnt_nx   = cap_gnt;
          valid_nx = 1'b1;
          tcnt_nx  = '0;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        tcnt_nx = tcnt + 8'd1;
        if (bus_ack || tcnt == TC_LAST) begin
          timeout_nx = !bus_ack;
          valid_nx   = 1'b0;
          gnt_nx     = '0;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_data  <= '0;
      bus_valid <= 1'b0;
      bus_src   <= '0;
      gnt       <= '0;
      sel_err   <= 1'b0;
      timeout   <= 1'b0;
      rr_ptr    <= '0;
      tcnt      <= '0;
    end else begin
      state     <= state_nx;
      bus_data  <= data_nx;
      bus_valid <= valid_nx;
      bus_src   <= src_nx;
      gnt       <= gnt_nx;
      sel_err   <= sel_err_nx;
      timeout   <= timeout_nx;
      rr_ptr    <= rr_nx;
      tcnt      <= tcnt_nx;
    end
  end

`ifdef COMMON_BUS_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus_par <= 1'b0;
    else if (do_cap)
      bus_par <= ^cap_data;
  end
`endif

endmodule

// File: tb/tb_common_bus_arb.sv
// Directed self-checking bench for common_bus_arb (NUM_SRC=6, DATA_W=8, TIMEOUT=15).
module tb_common_bus_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [3:0]  sel;
  logic        sel_vld;
  logic [5:0]  req;
  logic [47:0] src_data;
  logic        bus_ack;
  logic [7:0]  bus_data;
  logic        bus_valid;
  logic [3:0]  bus_src;
  logic [5:0]  gnt;
  logic        sel_err;
  logic        timeout;
`ifdef COMMON_BUS_PARITY_EN
  logic        bus_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  common_bus_arb #(.NUM_SRC(6), .DATA_W(8), .SEL_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .sel_vld(sel_vld), .req(req),
    .src_data(src_data), .bus_ack(bus_ack), .bus_data(bus_data), .bus_valid(bus_valid),
    .bus_src(bus_src), .gnt(gnt), .sel_err(sel_err), .timeout(timeout)
`ifdef COMMON_BUS_PARITY_EN
    , .bus_par(bus_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [7:0] v);
    src_data[i*8 +: 8] = v;
  endtask

  initial begin
    int exp_order [4] = '{0, 2, 5, 0};
    int n;
    rst = 1'b1; mode = 1'b0; sel = '0; sel_vld = 1'b0; req = '0; bus_ack = 1'b0;
    for (int i = 0; i < 6; i++) set_src(i, 8'(8'h10 + i));
    set_src(3, 8'hA5);
    #12;
    chk("rst_valid", 32'(bus_valid), 0);
    chk("rst_data", 32'(bus_data), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_src", 32'(bus_src), 0);
    chk("rst_pulses", {sel_err, timeout}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // direct capture and hold
    sel = 4'd3; sel_vld = 1'b1;
    tick(); sel_vld = 1'b0;
    chk("dir_data", 32'(bus_data), 32'hA5);
    chk("dir_src", 32'(bus_src), 3);
    chk("dir_gnt", 32'(gnt), 32'b001000);
    chk("dir_valid", 32'(bus_valid), 1);
    set_src(3, 8'h00);
    tick();
    chk("dir_hold", 32'(bus_data), 32'hA5);
    bus_ack = 1'b1;
    tick(); bus_ack = 1'b0;
    chk("ack_valid", 32'(bus_valid), 0);
    chk("ack_gnt", 32'(gnt), 0);
    chk("ack_data", 32'(bus_data), 32'hA5);

    // bad selects (7 and boundary 6)
    for (int s = 7; s >= 6; s--) begin
      sel = 4'(s); sel_vld = 1'b1;
      tick(); sel_vld = 1'b0;
      chk("bad_err", 32'(sel_err), 1);
      chk("bad_valid", 32'(bus_valid), 0);
      chk("bad_data", 32'(bus_data), 32'hA5);
      tick();
      chk("bad_pulse", 32'(sel_err), 0);
    end

    // round-robin with immediate acks
    mode = 1'b1; req = 6'b100101;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1) << exp_order[k]);
      chk("rr_src", 32'(bus_src), 32'(exp_order[k]));
      chk("rr_data", 32'(bus_data), 32'(8'h10 + exp_order[k]));
      bus_ack = 1'b1;
      tick(); bus_ack = 1'b0;
      chk("rr_rel", 32'(bus_valid), 0);
    end
    req = '0; mode = 1'b0;
    tick();

    // timeout with no ack, last valid source
    sel = 4'd5; sel_vld = 1'b1;
    tick(); sel_vld = 1'b0;
    chk("to_src", 32'(bus_src), 5);
    n = 0;
    while (bus_valid && n < 40) begin
      if (timeout) chk("to_early", 32'(timeout), 0);
      n++;
      tick();
    end
    chk("to_len", 32'(n), 15);
    chk("to_pulse", 32'(timeout), 1);
    tick();
    chk("to_pulse_end", 32'(timeout), 0);

    // ack on the last cycle before timeout
    sel = 4'd1; sel_vld = 1'b1;
    tick(); sel_vld = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    chk("late_valid", 32'(bus_valid), 1);
    bus_ack = 1'b1;
    tick(); bus_ack = 1'b0;
    chk("late_rel", 32'(bus_valid), 0);
    chk("late_no_to", 32'(timeout), 0);

    // reset in the middle of DRIVE (rr_ptr was 1, grant 1 moves it to 2)
    mode = 1'b1; req = 6'b000010;
    tick();
    chk("mid_valid", 32'(bus_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus_valid), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_data", 32'(bus_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    req = 6'b111111;
    tick();
    chk("post_rst_gnt", 32'(gnt), 1);
    chk("post_rst_src", 32'(bus_src), 0);
    req = '0; mode = 1'b0; bus_ack = 1'b1;
    tick(); bus_ack = 1'b0;

`ifdef COMMON_BUS_PARITY_EN
    set_src(3, 8'hA5);
    sel = 4'd3; sel_vld = 1'b1;
    tick(); sel_vld = 1'b0;
    chk("par_a5", 32'(bus_par), 0);
    bus_ack = 1'b1;
    tick(); bus_ack = 1'b0;
    set_src(3, 8'h07);
    sel_vld = 1'b1;
    tick(); sel_vld = 1'b0;
    chk("par_07", 32'(bus_par), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
